// File: rtl/wm8731_cfg_seq_if.sv
// I2C write-engine port bundle shared by the WM8731 configuration sequencer
// (master side) and the I2C engine (slave side).
//
// Handshake: the master raises i2c_req with i2c_dev/i2c_data already valid
// and holds all three stable until the engine answers. The engine answers
// with exactly one single-cycle pulse, either i2c_done (write ACKed) or
// i2c_nack (write NACKed). The master drops i2c_req on the clock edge that
// samples the pulse. If neither pulse arrives within the timeout window,
// the master withdraws the request on its own. A pulse seen while i2c_req
// is low has no meaning. If both pulses arrive together, i2c_done wins.
interface wm8731_cfg_seq_if;
   logic        i2c_req;
   logic [6:0]  i2c_dev;
   logic [15:0] i2c_data;
   logic        i2c_done;
   logic        i2c_nack;

   modport master (
      output i2c_req,
      output i2c_dev,
      output i2c_data,
      input  i2c_done,
      input  i2c_nack
   );

   modport slave (
      input  i2c_req,
      input  i2c_dev,
      input  i2c_data,
      output i2c_done,
      output i2c_nack
   );
endinterface

// File: rtl/wm8731_cfg_seq.sv
// WM8731 configuration sequencer. After INIT it waits for codec power-up,
// then writes a fixed 8-word register table through the I2C engine, with
// per-write retry and timeout. Once configured it services headphone-volume
// writes. All outputs are registered. The FSM state is visible on state_dbg.
module wm8731_cfg_seq #(
   parameter int         PWRUP_CYCLES   = 50000,
   parameter int         GAP_CYCLES     = 64,
   parameter int         TIMEOUT_CYCLES = 20000,
   parameter int         MAX_RETRY      = 3,
   parameter logic [6:0] DEV_ADDR       = 7'h1A
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    INIT,
   output logic                    INIT_FINISH,
   output logic                    INIT_ERROR,
   input  logic                    vol_req,
   input  logic [6:0]              vol,
   output logic                    vol_ack,
   wm8731_cfg_seq_if.master        i2c,
   output logic [2:0]              cfg_idx,
   output logic [3:0]              state_dbg
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_PWR_WAIT  = 4'd1,
      S_ISSUE     = 4'd2,
      S_WAIT_RSP  = 4'd3,
      S_GAP       = 4'd4,
      S_DONE      = 4'd5,
      S_ERROR     = 4'd6,
      S_VOL_ISSUE = 4'd7,
      S_VOL_WAIT  = 4'd8
   } state_t;

   // Terminal counts: a counter value equal to these ends the wait.
   localparam logic [31:0] PWR_LAST  = 32'(PWRUP_CYCLES - 1);
   localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
   localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  retry_q, retry_d;
   logic [2:0]  idx_q, idx_d;
   logic        req_q, req_d;
   logic [15:0] data_q, data_d;
   logic [15:0] vol_word_q, vol_word_d;
   logic        finish_q, finish_d;
   logic        error_q, error_d;
   logic        vol_ack_q, vol_ack_d;
   logic        start;
   logic        rsp_fail;

   // Codec register table: {reg_addr[6:0], reg_data[8:0]}.
   function automatic logic [15:0] cfg_word(input logic [2:0] idx);
      logic [15:0] w;
      case (idx)
         3'd0:    w = 16'h1E00;  // reset
         3'd1:    w = 16'h0C00;  // power all on
         3'd2:    w = 16'h0812;  // DAC to output
         3'd3:    w = 16'h0A00;  // digital path
         3'd4:    w = 16'h0E02;  // I2S, 16-bit, slave
         3'd5:    w = 16'h1000;  // 48 kHz normal
         3'd6:    w = 16'h0579;  // HP both, 0 dB
         default: w = 16'h1201;  // active
      endcase
      return w;
   endfunction

   assign start    = INIT && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
   assign rsp_fail = i2c.i2c_nack || (cnt_q == TO_LAST);

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      retry_d    = retry_q;
      idx_d      = idx_q;
      req_d      = req_q;
      data_d     = data_q;
      vol_word_d = vol_word_q;
      vol_ack_d  = 1'b0;

      case (state_q)
         S_PWR_WAIT: begin
            if (cnt_q == PWR_LAST) begin
               cnt_d   = '0;
               state_d = S_ISSUE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_ISSUE: begin
            req_d   = 1'b1;
            data_d  = cfg_word(idx_q);
            cnt_d   = '0;
            state_d = S_WAIT_RSP;
         end
         S_WAIT_RSP: begin
            if (i2c.i2c_done) begin
               req_d   = 1'b0;
               retry_d = '0;
               cnt_d   = '0;
               if (idx_q == 3'd7) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = S_GAP;
               end
            end else if (rsp_fail) begin
               req_d = 1'b0;
               cnt_d = '0;
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 8'd1;
                  state_d = S_GAP;
               end else begin
                  state_d = S_ERROR;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_ISSUE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         S_DONE: begin
            if (vol_req) begin
               vol_word_d = {7'h02, 1'b1, 1'b0, vol};
               retry_d    = '0;
               state_d    = S_VOL_ISSUE;
            end
         end
         S_VOL_ISSUE: begin
            req_d   = 1'b1;
            data_d  = vol_word_q;
            cnt_d   = '0;
            state_d = S_VOL_WAIT;
         end
         S_VOL_WAIT: begin
            if (i2c.i2c_done) begin
               req_d     = 1'b0;
               retry_d   = '0;
               cnt_d     = '0;
               vol_ack_d = 1'b1;
               state_d   = S_DONE;
            end else if (rsp_fail) begin
               req_d = 1'b0;
               cnt_d = '0;
               if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 8'd1;
                  state_d = S_VOL_ISSUE;
               end else begin
                  retry_d   = '0;
                  vol_ack_d = 1'b1;
                  state_d   = S_DONE;
               end
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: begin
            // S_IDLE and S_ERROR only leave on INIT, handled below.
            state_d = state_q;
         end
      endcase

      // INIT restarts the whole sequence from IDLE, DONE or ERROR.
      if (start) begin
         state_d = S_PWR_WAIT;
         cnt_d   = '0;
         retry_d = '0;
         idx_d   = '0;
         req_d   = 1'b0;
      end

      finish_d = (state_d == S_DONE) || (state_d == S_VOL_ISSUE) || (state_d == S_VOL_WAIT);
      error_d  = (state_d == S_ERROR);
   end

   // State and registered-output update.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         retry_q    <= '0;
         idx_q      <= '0;
         req_q      <= 1'b0;
         data_q     <= '0;
         vol_word_q <= '0;
         finish_q   <= 1'b0;
         error_q    <= 1'b0;
         vol_ack_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         retry_q    <= retry_d;
         idx_q      <= idx_d;
         req_q      <= req_d;
         data_q     <= data_d;
         vol_word_q <= vol_word_d;
         finish_q   <= finish_d;
         error_q    <= error_d;
         vol_ack_q  <= vol_ack_d;
      end
   end

   assign i2c.i2c_req  = req_q;
   assign i2c.i2c_data = data_q;
   assign i2c.i2c_dev  = DEV_ADDR;
   assign INIT_FINISH  = finish_q;
   assign INIT_ERROR   = error_q;
   assign vol_ack      = vol_ack_q;
   assign cfg_idx      = idx_q;
   assign state_dbg    = state_q;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Bench for wm8731_cfg_seq: directed init/volume/reset scenarios against a
// scripted I2C engine, with an expected-word queue checked on every request.
module tb_wm8731_cfg_seq;

   localparam int P_PWR   = 20;
   localparam int P_GAP   = 4;
   localparam int P_TO    = 300;
   localparam int P_RETRY = 3;
   localparam int DELAY   = 100;

   localparam int K_DONE = 0;
   localparam int K_NACK = 1;
   localparam int K_NONE = 2;

   logic       clk;
   logic       rst_n;
   logic       init;
   logic       init_finish;
   logic       init_error;
   logic       vol_req;
   logic [6:0] vol;
   logic       vol_ack;
   logic [2:0] cfg_idx;
   logic [3:0] state_dbg;

   wm8731_cfg_seq_if bus ();

   wm8731_cfg_seq #(
      .PWRUP_CYCLES   (P_PWR),
      .GAP_CYCLES     (P_GAP),
      .TIMEOUT_CYCLES (P_TO),
      .MAX_RETRY      (P_RETRY),
      .DEV_ADDR       (7'h1A)
   ) dut (
      .Clk         (clk),
      .Reset       (rst_n),
      .INIT        (init),
      .INIT_FINISH (init_finish),
      .INIT_ERROR  (init_error),
      .vol_req     (vol_req),
      .vol         (vol),
      .vol_ack     (vol_ack),
      .i2c         (bus.master),
      .cfg_idx     (cfg_idx),
      .state_dbg   (state_dbg)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [15:0] exp_q[$];
   int          resp_q[$];
   int          vol_ack_cnt = 0;

   logic [15:0] cfg_tab [8];
   initial begin
      cfg_tab[0] = 16'h1E00; cfg_tab[1] = 16'h0C00;
      cfg_tab[2] = 16'h0812; cfg_tab[3] = 16'h0A00;
      cfg_tab[4] = 16'h0E02; cfg_tab[5] = 16'h1000;
      cfg_tab[6] = 16'h0579; cfg_tab[7] = 16'h1201;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [15:0] word, input int kind);
      exp_q.push_back(word);
      resp_q.push_back(kind);
   endtask

   // Scripted I2C engine: one response per request rise, from resp_q.
   initial begin
      int   r_cnt;
      int   r_kind;
      logic r_active;
      logic r_after;
      logic r_prev;
      r_cnt = 0; r_kind = K_DONE; r_active = 1'b0; r_after = 1'b0; r_prev = 1'b0;
      bus.i2c_done = 1'b0;
      bus.i2c_nack = 1'b0;
      forever begin
         @(negedge clk);
         bus.i2c_done = 1'b0;
         bus.i2c_nack = 1'b0;
         if (!rst_n) begin
            r_active = 1'b0;
            r_after  = 1'b0;
         end else if (r_after) begin
            r_after = 1'b0;
            check("req_drop_after_rsp", {31'd0, bus.i2c_req}, 32'd0);
         end else if (r_active) begin
            r_cnt++;
            if (r_kind == K_NONE) begin
               if (!bus.i2c_req) begin
                  check("timeout_len", r_cnt, P_TO);
                  r_active = 1'b0;
               end else if (r_cnt > P_TO + 5) begin
                  check("timeout_expired", 32'd0, 32'd1);
                  r_active = 1'b0;
               end
            end else if (r_cnt == DELAY) begin
               if (r_kind == K_DONE) bus.i2c_done = 1'b1;
               else                  bus.i2c_nack = 1'b1;
               r_active = 1'b0;
               r_after  = 1'b1;
            end
         end else if (bus.i2c_req && !r_prev) begin
            r_kind   = (resp_q.size() != 0) ? resp_q.pop_front() : K_DONE;
            r_active = 1'b1;
            r_cnt    = 0;
         end
         r_prev = bus.i2c_req;
      end
   end

   // Monitor: compares each request word with the scoreboard queue.
   initial begin
      logic        m_prev;
      logic [15:0] m_data;
      logic        m_stable;
      int          low_cnt;
      m_prev = 1'b0; m_data = '0; m_stable = 1'b1; low_cnt = 1000;
      forever begin
         @(negedge clk);
         if (vol_ack) vol_ack_cnt++;
         if (bus.i2c_req && !m_prev) begin
            if (exp_q.size() == 0) begin
               check("unexpected_req", {16'd0, bus.i2c_data}, 32'hFFFF_FFFF);
            end else begin
               check("req_word", {16'd0, bus.i2c_data}, {16'd0, exp_q.pop_front()});
            end
            check("dev_addr", {25'd0, bus.i2c_dev}, 32'h1A);
            if (!init_finish) check("init_gap", {31'd0, low_cnt > P_GAP}, 32'd1);
            else              check("vol_gap", {31'd0, low_cnt >= 1}, 32'd1);
            m_data   = bus.i2c_data;
            m_stable = 1'b1;
            low_cnt  = 0;
         end else if (bus.i2c_req) begin
            if (bus.i2c_data !== m_data) m_stable = 1'b0;
         end else begin
            if (m_prev) check("data_stable", {31'd0, m_stable}, 32'd1);
            low_cnt++;
         end
         m_prev = bus.i2c_req;
      end
   end

   // Bounded wait: 0 finish, 1 error, 2 vol_ack, 3 index 4 request live.
   task automatic wait_cond(input int sel, input int bound, input string name);
      int   n;
      logic hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < bound) begin
         @(negedge clk);
         n++;
         case (sel)
            0:       hit = init_finish;
            1:       hit = init_error;
            2:       hit = vol_ack;
            default: hit = (cfg_idx == 3'd4) && bus.i2c_req;
         endcase
      end
      check(name, {31'd0, hit}, 32'd1);
   endtask

   task automatic pulse_init();
      @(negedge clk);
      init = 1'b1;
      @(negedge clk);
      init = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Directed scenarios.
   initial begin
      int lat;
      rst_n   = 1'b0;
      init    = 1'b0;
      vol_req = 1'b0;
      vol     = 7'h00;
      idle_cycles(3);
      check("rst_req", {31'd0, bus.i2c_req}, 32'd0);
      check("rst_data", {16'd0, bus.i2c_data}, 32'd0);
      check("rst_dev", {25'd0, bus.i2c_dev}, 32'h1A);
      check("rst_flags", {29'd0, init_finish, init_error, vol_ack}, 32'd0);
      check("rst_idx", {29'd0, cfg_idx}, 32'd0);
      rst_n = 1'b1;
      idle_cycles(2);

      // Clean init with power-up latency.
      for (int i = 0; i < 8; i++) push(cfg_tab[i], K_DONE);
      @(negedge clk);
      init = 1'b1;
      @(negedge clk);
      init = 1'b0;
      lat = 1;
      while (!bus.i2c_req && lat < P_PWR + 20) begin
         @(negedge clk);
         lat++;
      end
      check("init_latency", lat, P_PWR + 2);
      wait_cond(0, 2000, "clean_finish");
      check("clean_error", {31'd0, init_error}, 32'd0);
      check("clean_idx", {29'd0, cfg_idx}, 32'd7);
      check("clean_queue", exp_q.size(), 0);

      // Volume write, ACKed.
      vol_ack_cnt = 0;
      push(16'h0550, K_DONE);
      vol = 7'h50;
      vol_req = 1'b1;
      wait_cond(2, 500, "vol_ack_seen");
      vol_req = 1'b0;
      idle_cycles(10);
      check("vol_ack_once", vol_ack_cnt, 1);
      check("vol_finish", {31'd0, init_finish}, 32'd1);
      check("vol_queue", exp_q.size(), 0);

      // Volume write, every attempt NACKed.
      vol_ack_cnt = 0;
      for (int i = 0; i < 4; i++) push(16'h0530, K_NACK);
      vol = 7'h30;
      vol_req = 1'b1;
      wait_cond(2, 1000, "vol_giveup_ack");
      vol_req = 1'b0;
      idle_cycles(10);
      check("vol_giveup_once", vol_ack_cnt, 1);
      check("vol_giveup_flags", {30'd0, init_finish, init_error}, 32'd2);
      check("vol_giveup_queue", exp_q.size(), 0);

      // Single NACK at index 3, restarted from DONE.
      for (int i = 0; i < 8; i++) begin
         if (i == 3) push(cfg_tab[3], K_NACK);
         push(cfg_tab[i], K_DONE);
      end
      pulse_init();
      check("restart_clears_finish", {31'd0, init_finish}, 32'd0);
      wait_cond(0, 3000, "nack_finish");
      check("nack_error", {31'd0, init_error}, 32'd0);
      check("nack_queue", exp_q.size(), 0);

      // Retry exhaustion at index 5.
      for (int i = 0; i < 5; i++) push(cfg_tab[i], K_DONE);
      for (int i = 0; i < 4; i++) push(cfg_tab[5], K_NACK);
      pulse_init();
      wait_cond(1, 3000, "exhaust_error");
      idle_cycles(100);
      check("exhaust_flags", {30'd0, init_finish, init_error}, 32'd1);
      check("exhaust_req_low", {31'd0, bus.i2c_req}, 32'd0);
      check("exhaust_queue", exp_q.size(), 0);

      // Timeout at index 0, restarted from ERROR.
      for (int i = 0; i < 4; i++) push(cfg_tab[0], K_NONE);
      pulse_init();
      check("restart_clears_error", {31'd0, init_error}, 32'd0);
      wait_cond(1, 4 * (P_TO + 20) + 100, "timeout_error");
      check("timeout_queue", exp_q.size(), 0);
      check("timeout_idx", {29'd0, cfg_idx}, 32'd0);

      // Reset while index 4 is on the bus.
      for (int i = 0; i < 4; i++) push(cfg_tab[i], K_DONE);
      push(cfg_tab[4], K_NONE);
      pulse_init();
      wait_cond(3, 2000, "idx4_req");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_req", {31'd0, bus.i2c_req}, 32'd0);
      check("midrst_data", {16'd0, bus.i2c_data}, 32'd0);
      check("midrst_flags", {29'd0, init_finish, init_error, vol_ack}, 32'd0);
      check("midrst_idx", {29'd0, cfg_idx}, 32'd0);
      idle_cycles(3);
      rst_n = 1'b1;
      idle_cycles(100);
      check("midrst_no_req", {31'd0, bus.i2c_req}, 32'd0);
      check("midrst_queue", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
